// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly in front of an async-read instruction memory.
//   Owns the program counter, presents it combinationally as the memory
//   address, and captures the returned word into the IF/ID register together
//   with the wrapped pc+1 of that word.
//
//   Per-edge priority: reset > jump > branch_taken > stall > normal fetch.
//   A redirect squashes the wrong-path word that was in flight by loading a
//   NOP with valid=0.
//
//   Optional feature, enabled by defining the macro HALT_DETECT_EN:
//     a normally fetched word equal to HALT_WORD is latched into IF/ID, the
//     pc freezes and the stage enters a HALTED state that only reset leaves.
//   With the macro undefined the stage has a single RUN behaviour, halted is
//   tied low and HALT_WORD is fetched like any other instruction.
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'h0000000C
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus1,
    output logic                  if_id_valid,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // Sequential successor; the adder's natural overflow gives the wrap to 0.
    assign pc_plus1 = pc + PC_STEP;

    // The memory is read asynchronously, so the address is the pc itself.
    assign imem_addr = pc;

    // jump outranks branch_taken when both are raised together.
    assign redirect        = jump | branch_taken;
    assign redirect_target = jump ? jump_target : branch_target;

`ifdef HALT_DETECT_EN
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0] state;
    logic       is_halt_word;

    // Only consulted on a normal fetch; stall and redirect cycles ignore it.
    assign is_halt_word = (imem_data == HALT_WORD);
    assign halted       = (state == HALTED);
`else
    logic unused_halt_word;

    // HALT_WORD has no meaning without halt detection.
    assign unused_halt_word = ^HALT_WORD;
    assign halted           = 1'b0;
`endif

    // PC and IF/ID register update, resolved in priority order each edge.
    // NOTE: non-blocking assignments keep every register reading the values
    // from before this edge, so pc_plus1 and imem_data refer to the old pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
`ifdef HALT_DETECT_EN
            state          <= RUN;
`endif
        end
`ifdef HALT_DETECT_EN
        else if (state == HALTED) begin
            // Frozen: pc holds, decode sees bubbles, all control ignored.
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end
`endif
        else if (redirect) begin
            // The word addressed this cycle is on the wrong path; drop it.
            pc             <= redirect_target;
            if_id_instr    <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end
        else if (!stall) begin
            if_id_instr    <= imem_data;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid    <= 1'b1;
`ifdef HALT_DETECT_EN
            // The halt word itself still reaches decode; the pc stops on it.
            if (is_halt_word) begin
                state <= HALTED;
            end else begin
                pc <= pc_plus1;
            end
`else
            pc             <= pc_plus1;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed scenarios followed by a randomized run. Expected values come
//   from a behavioural model of the fetch rules (integer pc arithmetic modulo
//   the memory depth) plus explicit constants at the directed checkpoints.
//   Halt scenarios are included when HALT_DETECT_EN is defined.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] HALT = 32'h0000000C;
`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic [DW-1:0] if_id_instr;
    logic [AW-1:0] if_id_pc_plus1;
    logic          if_id_valid;
    logic          halted;

    logic [DW-1:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    // behavioural model state
    int            m_pc;
    logic [DW-1:0] m_instr;
    int            m_ppc;
    bit            m_valid;
    bit            m_halted;

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus1(if_id_pc_plus1),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    // Asynchronous-read instruction memory.
    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ordinary word: bit 31 set guarantees it never equals HALT.
    function automatic logic [DW-1:0] rand_word();
        return $urandom() | 32'h8000_0000;
    endfunction

    // Apply the fetch rules for one clock edge to the model.
    task automatic model_edge(input bit r, input bit st, input bit bt, input int btg,
                              input bit j, input int jtg);
        logic [DW-1:0] w;
        if (r) begin
            m_pc = 0; m_instr = '0; m_ppc = 0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_instr = '0; m_valid = 0;
        end else if (j || bt) begin
            m_pc = j ? jtg : btg;
            m_instr = '0; m_ppc = 0; m_valid = 0;
        end else if (!st) begin
            w       = mem[m_pc];
            m_instr = w;
            m_ppc   = (m_pc + 1) % DEPTH;
            m_valid = 1;
            if (HALT_EN && w == HALT) m_halted = 1;
            else                      m_pc = (m_pc + 1) % DEPTH;
        end
    endtask

    task automatic compare_all();
        check("pc",       64'(imem_addr),      64'(m_pc));
        check("instr",    64'(if_id_instr),    64'(m_instr));
        check("pc_plus1", 64'(if_id_pc_plus1), 64'(m_ppc));
        check("valid",    64'(if_id_valid),    64'(m_valid));
        check("halted",   64'(halted),         64'(m_halted));
    endtask

    // Drive one cycle of inputs, clock it, update the model, then compare.
    task automatic cycle(input bit r, input bit st, input bit bt, input int btg,
                         input bit j, input int jtg);
        reset         = r;
        stall         = st;
        branch_taken  = bt;
        branch_target = AW'(btg);
        jump          = j;
        jump_target   = AW'(jtg);
        @(posedge clk);
        model_edge(r, st, bt, btg, j, jtg);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        mem[0] = 32'hA000_0001;
        mem[1] = 32'hB000_0002;
        mem[2] = 32'hC000_0003;
        reset = 1; stall = 0; branch_taken = 0; branch_target = '0;
        jump = 0; jump_target = '0;

        // 1. reset then sequential fetch
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_pc", 64'(imem_addr), 0);
        check("rst_valid", 64'(if_id_valid), 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("seq_a", 64'(if_id_instr), 64'h0A000_0001);
        check("seq_a_pc1", 64'(if_id_pc_plus1), 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("seq_b", 64'(if_id_instr), 64'h0B000_0002);
        cycle(0, 0, 0, 0, 0, 0);
        check("seq_c", 64'(if_id_instr), 64'h0C000_0003);
        check("seq_c_pc1", 64'(if_id_pc_plus1), 3);
        check("seq_addr", 64'(imem_addr), 3);

        // 2. wrap from 63 to 0
        mem[63] = 32'hEEEE_0063;
        mem[0]  = 32'hFFFF_0000;
        cycle(0, 0, 1, 63, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("wrap_pc", 64'(imem_addr), 0);
        check("wrap_x", 64'(if_id_instr), 64'hEEEE_0063);
        check("wrap_pc1", 64'(if_id_pc_plus1), 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("wrap_y", 64'(if_id_instr), 64'hFFFF_0000);

        // 3. stall three cycles at pc=5
        cycle(0, 0, 0, 0, 1, 4);
        cycle(0, 0, 0, 0, 0, 0);
        check("pre_stall_pc", 64'(imem_addr), 5);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("stall_pc", 64'(imem_addr), 5);
        check("stall_instr", 64'(if_id_instr), 64'(mem[4]));
        cycle(0, 0, 0, 0, 0, 0);
        check("post_stall", 64'(if_id_instr), 64'(mem[5]));

        // 4. redirects
        cycle(0, 0, 0, 0, 1, 8);
        cycle(0, 0, 1, 20, 0, 0);
        check("br_pc", 64'(imem_addr), 20);
        check("br_valid", 64'(if_id_valid), 0);
        check("br_instr", 64'(if_id_instr), 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("br_fetch", 64'(if_id_instr), 64'(mem[20]));
        check("br_fetch_v", 64'(if_id_valid), 1);
        cycle(0, 1, 1, 20, 1, 40);
        check("jmp_pc", 64'(imem_addr), 40);
        check("jmp_valid", 64'(if_id_valid), 0);

`ifdef HALT_DETECT_EN
        // 5. halt detection
        mem[3] = HALT;
        cycle(1, 0, 0, 0, 0, 0);
        run(4);
        check("halt_flag", 64'(halted), 1);
        check("halt_pc", 64'(imem_addr), 3);
        check("halt_word", 64'(if_id_instr), 64'(HALT));
        cycle(0, 0, 0, 0, 0, 0);
        check("halt_bubble", 64'(if_id_valid), 0);
        cycle(0, 1, 1, 9, 1, 30);
        check("halt_jmp_ign", 64'(imem_addr), 3);
        cycle(1, 0, 0, 0, 0, 0);
        check("halt_clr", 64'(halted), 0);
        check("halt_clr_pc", 64'(imem_addr), 0);
        mem[3] = rand_word();
`endif

        // 6. reset during a stall at pc=17
        cycle(0, 0, 0, 0, 1, 17);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("mid_rst_pc", 64'(imem_addr), 0);
        check("mid_rst_valid", 64'(if_id_valid), 0);
        check("mid_rst_halted", 64'(halted), 0);

        // randomized run against the model
        for (int n = 0; n < 400; n++) begin
            int rr;
            rr = int'($urandom_range(0, 99));
            if (rr < 20) mem[$urandom_range(0, DEPTH - 1)] = rand_word();
            if (HALT_EN && rr == 50) mem[$urandom_range(0, DEPTH - 1)] = HALT;
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, DEPTH - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
